// File: rtl/noc_arb_pkg.sv
// Shared types and helpers for the NoC output-port arbiter and future allocators.
package noc_arb_pkg;

  localparam int MAX_PORTS = 16;
  localparam int MAX_IDX_W = 4;

  typedef logic [MAX_PORTS-1:0] port_vec_t;
  typedef logic [MAX_IDX_W-1:0] port_idx_t;

  // Arbiter state value meaning "no port selected".
  localparam port_vec_t IDLE = '0;

  // One-hot winner of a round-robin search over the first n bits of req,
  // beginning at index start and wrapping; all-zero when nothing requests.
  function automatic port_vec_t rr_first(port_vec_t req, port_idx_t start, int n);
    port_vec_t win;
    logic      found;
    int        idx;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int d = 0; d < MAX_PORTS; d++) begin
      if (d < n) begin
        idx = (int'(start) + d) % n;
        if (!found && req[idx[MAX_IDX_W-1:0]]) begin
          win[idx[MAX_IDX_W-1:0]] = 1'b1;
          found = 1'b1;
        end else begin
          found = found;
        end
      end else begin
        found = found;
      end
    end
    return win;
  endfunction

  // Index of the set bit of a one-hot vector (0 for an all-zero vector).
  function automatic port_idx_t onehot2idx(port_vec_t oh);
    port_idx_t idx;
    idx = '0;
    for (int i = 0; i < MAX_PORTS; i++) begin
      idx = idx | (oh[i] ? port_idx_t'(i) : port_idx_t'(0));
    end
    return idx;
  endfunction

endpackage

// File: rtl/noc_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate the request vector so that the
// start index lands at bit 0, take the lowest set bit, rotate the winner back.
module rr_pick #(
  parameter int NUM_PORTS = 5,
  parameter int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     start,
  output logic [NUM_PORTS-1:0] winner
);

  logic [2*NUM_PORTS-1:0] dbl_s;
  logic [2*NUM_PORTS-1:0] unrot_s;
  logic [NUM_PORTS-1:0]   rot_s;
  logic [NUM_PORTS-1:0]   rot_win_s;
  logic                   found_s;

  // Rotate, priority-encode from bit 0 upward, then undo the rotation.
  always_comb begin
    dbl_s     = {req, req} >> start;
    rot_s     = dbl_s[NUM_PORTS-1:0];
    rot_win_s = '0;
    found_s   = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (rot_s[i] && !found_s) begin
        rot_win_s[i] = 1'b1;
        found_s      = 1'b1;
      end else begin
        rot_win_s[i] = 1'b0;
      end
    end
    unrot_s = {rot_win_s, rot_win_s} << start;
    winner  = unrot_s[2*NUM_PORTS-1:NUM_PORTS];
  end

endmodule

// File: rtl/noc_rr_arbiter.sv
// Round-robin output-port arbiter: selects one requesting input port for the
// crossbar, runs the RTS/DCTS handshake downstream and optionally limits how
// many back-to-back transfers one port may take while others wait.
module noc_rr_arbiter
  import noc_arb_pkg::*;
#(
  parameter int NUM_PORTS = 5,
  parameter int MAX_BURST = 0,
  parameter int CNT_W     = $clog2(MAX_BURST + 2)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 dcts,
  output logic [NUM_PORTS-1:0] grant,
  output logic [NUM_PORTS-1:0] xbar_sel,
  output logic                 rts
);

  localparam int                   IDX_W    = $clog2(NUM_PORTS);
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_PORTS - 1);
  localparam logic [NUM_PORTS-1:0] IDLE_S   = NUM_PORTS'(IDLE);
  localparam logic [CNT_W-1:0]     MAX_C    = CNT_W'(MAX_BURST);

  logic [NUM_PORTS-1:0] state_r;
  logic [NUM_PORTS-1:0] state_nxt_s;
  logic                 rts_r;
  logic                 rts_nxt_s;
  logic [IDX_W-1:0]     last_ptr_r;
  logic [IDX_W-1:0]     last_ptr_nxt_s;
  logic [CNT_W-1:0]     burst_cnt_r;
  logic [CNT_W-1:0]     burst_cnt_nxt_s;

  port_vec_t            state_ext_s;
  logic [IDX_W-1:0]     cur_idx_s;
  logic [IDX_W-1:0]     base_s;
  logic [IDX_W-1:0]     start_s;
  logic [NUM_PORTS-1:0] pick_s;
  logic [NUM_PORTS-1:0] arb_s;
  logic                 idle_s;
  logic                 expired_s;
  logic                 stay_s;
  logic                 stall_s;
  logic                 transfer_s;

  assign xbar_sel = state_r;
  assign rts      = rts_r;
  assign grant    = state_r & {NUM_PORTS{rts_r & dcts}};

  // Decode the current port and the round-robin search start point.
  always_comb begin
    state_ext_s                = '0;
    state_ext_s[NUM_PORTS-1:0] = state_r;
    cur_idx_s                  = IDX_W'(onehot2idx(state_ext_s));
    idle_s                     = (state_r == IDLE_S);
    if (idle_s) begin
      base_s = last_ptr_r;
    end else begin
      base_s = cur_idx_s;
    end
    if (base_s == LAST_IDX) begin
      start_s = '0;
    end else begin
      start_s = base_s + IDX_W'(1);
    end
  end

  rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_rr_pick (
    .req    (req),
    .start  (start_s),
    .winner (pick_s)
  );

  // Arbitration, handshake and burst bookkeeping for the next cycle.
  always_comb begin
    // The counter saturates at MAX_C, so equality is the ">= limit" test.
    expired_s  = (MAX_BURST != 0) && (burst_cnt_r == MAX_C);
    stay_s     = !idle_s && ((req & state_r) != IDLE_S) && !expired_s;
    stall_s    = rts_r & ~dcts;
    transfer_s = rts_r & dcts & !idle_s;

    if (stay_s) begin
      arb_s = state_r;
    end else begin
      arb_s = pick_s;
    end

    // A raised RTS is never withdrawn: hold the selection until DCTS.
    if (stall_s) begin
      state_nxt_s = state_r;
    end else begin
      state_nxt_s = arb_s;
    end

    // One RTS pulse per transfer, with a gap of at least one cycle.
    if (idle_s) begin
      rts_nxt_s = 1'b0;
    end else if (rts_r && dcts) begin
      rts_nxt_s = 1'b0;
    end else begin
      rts_nxt_s = 1'b1;
    end

    if (transfer_s) begin
      last_ptr_nxt_s = cur_idx_s;
    end else begin
      last_ptr_nxt_s = last_ptr_r;
    end

    // An expired port that is the only requester keeps the grant but
    // starts a fresh burst.
    if (stall_s) begin
      burst_cnt_nxt_s = burst_cnt_r;
    end else if (state_nxt_s != state_r) begin
      burst_cnt_nxt_s = '0;
    end else if (expired_s) begin
      burst_cnt_nxt_s = '0;
    end else if (transfer_s && (burst_cnt_r != MAX_C)) begin
      burst_cnt_nxt_s = burst_cnt_r + CNT_W'(1);
    end else begin
      burst_cnt_nxt_s = burst_cnt_r;
    end
  end

  // Arbiter state registers with asynchronous reset to IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE_S;
      rts_r       <= 1'b0;
      last_ptr_r  <= LAST_IDX;
      burst_cnt_r <= '0;
    end else begin
      state_r     <= state_nxt_s;
      rts_r       <= rts_nxt_s;
      last_ptr_r  <= last_ptr_nxt_s;
      burst_cnt_r <= burst_cnt_nxt_s;
    end
  end

endmodule
